// File: rtl/filter_sample_ctrl.sv
// Avalon-MM slave that buffers filter output samples in a small FIFO, with
// backpressure or drop-on-full policy, flush, drop counter and a level irq.
module filter_sample_ctrl #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        irq
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam logic [1:0] ADDR_DROPCNT = 2'd3;

  logic [15:0]   mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          enable_q, enable_d;
  logic          irq_en_q, irq_en_d;
  logic          drop_mode_q, drop_mode_d;
  logic [7:0]    threshold_q, threshold_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic [15:0]   drops_q, drops_d;
  logic [31:0]   readdata_q, readdata_d;
  logic          irq_q, irq_d;

  logic empty, full, ctrl_wr, stat_wr, drop_wr, flush, data_rd;
  logic accept, pop, push, drop;
  logic unused_wd;

  // Decode of bus strobes and FIFO push/pop/drop qualification.
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign in_ready = enable_q & (drop_mode_q | ~full);
  assign ctrl_wr  = write & (address == ADDR_CONTROL);
  assign stat_wr  = write & (address == ADDR_STATUS);
  assign drop_wr  = write & (address == ADDR_DROPCNT);
  assign flush    = ctrl_wr & writedata[2];
  assign data_rd  = read & (address == ADDR_DATA);
  assign pop      = data_rd & ~empty & ~flush;
  assign accept   = in_valid & in_ready & ~flush;
  assign push     = accept & (~full | pop);
  assign drop     = accept & full & ~pop;
  assign unused_wd = ^{writedata[31:16], writedata[7:4]};

  // Next-state logic for FIFO state, control/status registers and outputs.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    enable_d    = enable_q;
    irq_en_d    = irq_en_q;
    drop_mode_d = drop_mode_q;
    threshold_d = threshold_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    drops_d     = drops_q;
    readdata_d  = readdata_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end

    if (ctrl_wr) begin
      enable_d    = writedata[0];
      irq_en_d    = writedata[1];
      drop_mode_d = writedata[3];
      threshold_d = writedata[15:8];
    end

    // Sticky flags: clear-on-write-1, with a same-cycle set taking priority.
    if (stat_wr && writedata[3]) overflow_d  = 1'b0;
    if (stat_wr && writedata[2]) underflow_d = 1'b0;
    if (drop)                    overflow_d  = 1'b1;
    if (data_rd && empty)        underflow_d = 1'b1;

    if (drop_wr)                         drops_d = '0;
    else if (drop && drops_q != 16'hFFFF) drops_d = drops_q + 16'd1;

    if (read) begin
      case (address)
        ADDR_DATA:    readdata_d = empty ? 32'h0 : {16'h0, mem[rd_ptr_q]};
        ADDR_STATUS:  readdata_d = {16'h0, 8'(count_q), 4'h0,
                                    overflow_q, underflow_q, full, empty};
        ADDR_CONTROL: readdata_d = {16'h0, threshold_q, 4'h0,
                                    drop_mode_q, 1'b0, irq_en_q, enable_q};
        default:      readdata_d = {16'h0, drops_q};
      endcase
    end

    irq_d = irq_en_q & (overflow_q |
                        ((threshold_q != 8'h0) && (8'(count_q) >= threshold_q)));
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      enable_q    <= 1'b0;
      irq_en_q    <= 1'b0;
      drop_mode_q <= 1'b0;
      threshold_q <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      drops_q     <= '0;
      readdata_q  <= '0;
      irq_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      enable_q    <= enable_d;
      irq_en_q    <= irq_en_d;
      drop_mode_q <= drop_mode_d;
      threshold_q <= threshold_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      drops_q     <= drops_d;
      readdata_q  <= readdata_d;
      irq_q       <= irq_d;
    end
  end

  // Sample storage; unreset, never exposed while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_data;
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_filter_sample_ctrl.sv
// Directed bench for filter_sample_ctrl; bus read results go through a
// scoreboard queue filled when the read is issued.
module tb_filter_sample_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];
  string       tag_q [$];

  filter_sample_ctrl #(.DEPTH(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .read      (read),
    .write     (write),
    .writedata (writedata),
    .readdata  (readdata),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    step();
    write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string tag);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    address = a; read = 1'b1;
    step();
    read = 1'b0;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: observed=empty scoreboard expected=entry", tag);
    end else begin
      chk(tag_q.pop_front(), readdata, exp_q.pop_front());
    end
  endtask

  task automatic push(input logic [15:0] d);
    in_data = d; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; address = '0; read = 1'b0; write = 1'b0;
    writedata = '0; in_data = '0; in_valid = 1'b0;
    step(); step();
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
    reset_n = 1'b1;
    step();
    chk("no_enable_ready", {31'h0, in_ready}, 32'h0);
    push(16'hDEAD);
    bus_read(2'd1, 32'h0000_0001, "no_enable_status");

    // Basic push/pop ordering.
    bus_write(2'd2, 32'h1);
    chk("enable_ready", {31'h0, in_ready}, 32'h1);
    push(16'h1234);
    push(16'hABCD);
    bus_read(2'd0, 32'h0000_1234, "data0");
    bus_read(2'd0, 32'h0000_ABCD, "data1");
    bus_read(2'd1, 32'h0000_0001, "status_empty");
    step();
    chk("readdata_hold", readdata, 32'h0000_0001);

    // Backpressure fill: 8 accepted, ready drops from the 9th cycle.
    begin
      int acc = 0;
      for (int i = 0; i < 10; i++) begin
        in_data = 16'h0200 + 16'(i); in_valid = 1'b1;
        chk($sformatf("bp_ready_%0d", i), {31'h0, in_ready}, {31'h0, (i < 8)});
        if (in_ready) acc++;
        step();
      end
      in_valid = 1'b0;
      chk("bp_accepted", 32'(acc), 32'd8);
    end
    bus_read(2'd1, 32'h0000_0802, "bp_status");
    bus_read(2'd3, 32'h0, "bp_dropcnt");
    bus_write(2'd2, 32'h5);
    bus_read(2'd1, 32'h0000_0001, "bp_flush_status");

    // Drop mode overflow.
    bus_write(2'd2, 32'h9);
    for (int i = 0; i < 10; i++) push(16'h0100 + 16'(i));
    bus_read(2'd3, 32'h2, "drop_dropcnt");
    bus_read(2'd1, 32'h0000_080A, "drop_status_ovf");
    bus_write(2'd1, 32'h8);
    bus_read(2'd1, 32'h0000_0802, "drop_status_clr");

    // Full in drop mode: push coinciding with pop is stored, no drop.
    in_data = 16'h5555; in_valid = 1'b1;
    bus_read(2'd0, 32'h0000_0100, "full_pushpop_data");
    in_valid = 1'b0;
    bus_read(2'd1, 32'h0000_0802, "full_pushpop_status");
    bus_read(2'd3, 32'h2, "full_pushpop_dropcnt");
    for (int i = 1; i < 8; i++)
      bus_read(2'd0, 32'h0000_0100 + 32'(i), $sformatf("drain_%0d", i));
    bus_read(2'd0, 32'h0000_5555, "drain_last");
    bus_read(2'd1, 32'h0000_0001, "drain_status");
    bus_write(2'd3, 32'h0);
    bus_read(2'd3, 32'h0, "dropcnt_clear");

    // Empty read with a same-cycle push: underflow, sample kept.
    in_data = 16'h7777; in_valid = 1'b1;
    bus_read(2'd0, 32'h0, "uf_data");
    in_valid = 1'b0;
    bus_read(2'd1, 32'h0000_0104, "uf_status");
    bus_read(2'd0, 32'h0000_7777, "uf_stored");
    bus_read(2'd1, 32'h0000_0005, "uf_status_empty");
    bus_write(2'd1, 32'h4);
    bus_read(2'd1, 32'h0000_0001, "uf_clear");

    // Threshold irq.
    bus_write(2'd2, 32'h0403);
    for (int i = 0; i < 4; i++) begin
      push(16'h0010 + 16'(i));
      chk($sformatf("irq_low_%0d", i), {31'h0, irq}, 32'h0);
    end
    step();
    chk("irq_high", {31'h0, irq}, 32'h1);
    bus_read(2'd1, 32'h0000_0400, "irq_status");

    // Flush with a same-cycle push.
    push(16'h0014);
    in_data = 16'h9999; in_valid = 1'b1;
    bus_write(2'd2, 32'h5);
    in_valid = 1'b0;
    bus_read(2'd1, 32'h0000_0001, "flush_status");
    bus_read(2'd2, 32'h0000_0001, "flush_ctrl");
    chk("flush_irq", {31'h0, irq}, 32'h0);

    // Reset during a push.
    bus_write(2'd2, 32'h0103);
    push(16'h0042);
    step();
    chk("pre_rst_irq", {31'h0, irq}, 32'h1);
    bus_read(2'd1, 32'h0000_0100, "pre_rst_status");
    in_data = 16'h4321; in_valid = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_readdata", readdata, 32'h0);
    chk("midrst_irq", {31'h0, irq}, 32'h0);
    chk("midrst_in_ready", {31'h0, in_ready}, 32'h0);
    step();
    in_valid = 1'b0;
    reset_n = 1'b1;
    step();
    chk("post_rst_ready", {31'h0, in_ready}, 32'h0);
    bus_read(2'd1, 32'h0000_0001, "post_rst_status");
    bus_write(2'd2, 32'h1);
    chk("post_rst_enable", {31'h0, in_ready}, 32'h1);
    bus_read(2'd0, 32'h0, "post_rst_data");
    bus_read(2'd1, 32'h0000_0005, "post_rst_uf");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/filter_sample_ctrl.md
FILTER_SAMPLE_CTRL -- requirements
Module: filter_sample_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO depth in 16-bit samples (power of 2, 2..16).
REQ-002 SHALL have port clk  input  1  system clock, all logic rising-edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port address  input  2  Avalon-MM slave word address.
REQ-005 SHALL have port read  input  1  Avalon read strobe, single cycle.
REQ-006 SHALL have port write  input  1  Avalon write strobe, single cycle.
REQ-007 SHALL have port writedata  input  32  Avalon write data.
REQ-008 SHALL have port readdata  output  32  Avalon read data, registered.
REQ-009 SHALL have port in_data  input  16  filter output sample.
REQ-010 SHALL have port in_valid  input  1  in_data valid.
REQ-011 SHALL have port in_ready  output  1  block accepts sample this cycle.
REQ-012 SHALL have port irq  output  1  level interrupt, registered.

Function
REQ-013 Register map SHALL be: 0 DATA (RO), 1 STATUS, 2 CONTROL (RW), 3 DROPCNT (RO).
REQ-014 readdata SHALL update one cycle after read is high, and SHALL hold its previous value on cycles without read.
REQ-015 DATA read SHALL return {16'h0, head sample} and pop one entry; on empty, it SHALL return 0, leave pointers unchanged, and set STATUS.underflow.
REQ-016 STATUS SHALL read {16'h0, count[7:0], 4'h0, overflow, underflow, full, empty} (bits 3..0); writing 1 to bit 3 or bit 2 SHALL clear that flag, and other bits SHALL ignore writes.
REQ-017 CONTROL SHALL hold enable[0], irq_en[1], flush[2], drop_mode[3], threshold[15:8]; flush SHALL self-clear and always read 0.
REQ-018 DROPCNT SHALL read {16'h0, drops[15:0]}, saturate at 16'hFFFF, and clear on any write to address 3.
REQ-019 Sample acceptance SHALL occur on in_valid & in_ready; an accepted sample SHALL be visible to a DATA read issued the next cycle.
REQ-020 Backpressure mode (drop_mode=0): in_ready SHALL be enable & !full, combinational from registered state.
REQ-021 Drop mode (drop_mode=1): in_ready SHALL be enable; an accepted sample while full with no same-cycle pop SHALL be discarded, set overflow, and increment drops.
REQ-022 Drop mode, full with push and pop in the same cycle: the push SHALL be stored, count SHALL stay DEPTH, and no drop SHALL occur.
REQ-023 Push and pop in the same cycle with count strictly between 0 and DEPTH SHALL leave count unchanged.
REQ-024 Push into an empty FIFO coinciding with a DATA read SHALL count as underflow, with the sample stored (no bypass).
REQ-025 count SHALL span 0..DEPTH, and pointers SHALL wrap modulo DEPTH; empty = (count==0) and full = (count==DEPTH).
REQ-026 A flush write SHALL zero count and pointers next cycle; a push or pop in the flush cycle SHALL be ignored; overflow, underflow and drops SHALL be unaffected.
REQ-027 enable=0 SHALL force in_ready low, while FIFO contents SHALL stay readable.
REQ-028 irq SHALL register irq_en & (overflow | (threshold!=0 & count>=threshold)) each cycle.
REQ-029 CONTROL and STATUS writes SHALL take effect on the cycle after the write strobe.

Reset
REQ-030 On reset_n low, all registers SHALL clear asynchronously: readdata=0, count=0, pointers=0, CONTROL=0, flags=0, drops=0, irq=0; hence in_ready=0.
REQ-031 Reset mid-transfer SHALL discard all FIFO contents; FIFO storage needs no reset, but reads SHALL never expose it while empty.
REQ-032 After reset release, the first push SHALL be accepted only once enable has been written 1.

Verification
REQ-033 Write CONTROL=0x1, push 0x1234, 0xABCD, then read DATA twice -> readdata 0x1234 then 0xABCD, each 1 cycle after read; STATUS then reads 0x0001.
REQ-034 DEPTH=8, drop_mode=0, hold in_valid for 10 cycles -> 8 accepted, in_ready low from the 9th, STATUS=0x0802, DROPCNT=0.
REQ-035 Write CONTROL=0x9, push 10 samples with no reads -> DROPCNT=2, overflow=1; writing STATUS 0x8 clears it -> STATUS=0x0802.
REQ-036 Full FIFO in drop mode, push 0x5555 coinciding with DATA read -> oldest returned, count stays 8, DROPCNT unchanged, last read yields 0x5555.
REQ-037 Read DATA when empty -> readdata 0, underflow=1; then write CONTROL=0x0403 with 4 pushes -> irq high 1 cycle after count reaches 4.
REQ-038 Load 5 samples, write CONTROL=0x5 (flush) -> STATUS=0x0001 next cycle; assert reset_n low mid-push -> all outputs 0 immediately.
